oled_pwr_seq: RTL

Power-up/power-down sequencer and pin arbiter for the Nexys Video SSD1306 OLED. It sits in the FPGA top level between the SoC SPI-master/I2S-mapped OLED pads and the board pins. It drives the VDD/VBAT rail enables and RES# in the datasheet order and shifts out the mandatory init/shutdown commands through its own SPI shifter. Once the panel is on, it hands SCK/MOSI/DC to the SoC.

---
 rtl/oled_seq_pkg.sv | 34 +++
 rtl/oled_spi_tx.sv | 68 ++++++
 rtl/oled_pwr_seq.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/oled_seq_pkg.sv
// rtl/oled_seq_pkg.sv - shared state encoding and command bytes for the OLED power sequencer
package oled_seq_pkg;

    typedef enum logic [3:0] {
        ST_OFF      = 4'd0,
        ST_VDD_ON   = 4'd1,
        ST_RST_LO   = 4'd2,
        ST_RST_HI   = 4'd3,
        ST_INIT_CMD = 4'd4,
        ST_VBAT_ON  = 4'd5,
        ST_DISP_ON  = 4'd6,
        ST_ON       = 4'd7,
        ST_DISP_OFF = 4'd8,
        ST_VBAT_OFF = 4'd9,
        ST_VDD_OFF  = 4'd10
    } state_t;

    localparam logic [7:0] CMD_DISP_OFF = 8'hAE;
    localparam logic [7:0] CMD_DISP_ON  = 8'hAF;
    localparam logic [7:0] CMD_CHG_PUMP = 8'h8D;
    localparam logic [7:0] CHG_PUMP_EN  = 8'h14;
    localparam logic [7:0] CMD_PRECHG   = 8'hD9;
    localparam logic [7:0] PRECHG_VAL   = 8'hF1;

    localparam int INIT_LEN = 5;
    localparam logic [7:0] INIT_BYTES [INIT_LEN] = '{
        CMD_DISP_OFF, CMD_CHG_PUMP, CHG_PUMP_EN, CMD_PRECHG, PRECHG_VAL
    };

    function automatic logic [7:0] init_byte(input logic [2:0] i);
        return (int'(i) < INIT_LEN) ? INIT_BYTES[i] : 8'h00;
    endfunction

endpackage

// File: rtl/oled_spi_tx.sv
// rtl/oled_spi_tx.sv - mode-0 MSB-first command byte shifter
module oled_spi_tx #(
    parameter int SCK_HALF = 5
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic       sck_o,
    output logic       mosi_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int HW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;

    logic [HW-1:0] half_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          sck_q;
    logic          busy_q;
    logic          done_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            half_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            sck_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i && !busy_q) begin
                shreg    <= data_i;
                busy_q   <= 1'b1;
                sck_q    <= 1'b0;
                half_cnt <= HW'(SCK_HALF - 1);
                bit_idx  <= '0;
            end else if (busy_q) begin
                if (half_cnt != '0) begin
                    half_cnt <= half_cnt - 1'b1;
                end else begin
                    half_cnt <= HW'(SCK_HALF - 1);
                    if (!sck_q) begin
                        sck_q <= 1'b1;
                    end else begin
                        // Falling edge: next bit is presented while SCK is low.
                        sck_q <= 1'b0;
                        if (bit_idx == 3'd7) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shreg   <= {shreg[6:0], 1'b0};
                        end
                    end
                end
            end
        end
    end

    assign sck_o  = sck_q;
    assign mosi_o = shreg[7];
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: rtl/oled_pwr_seq.sv
// rtl/oled_pwr_seq.sv - SSD1306 rail/reset sequencer with command shifter and SoC pin handoff
module oled_pwr_seq #(
    parameter int VDD_DLY_CYC  = 100000,
    parameter int RST_CYC      = 1000,
    parameter int VBAT_DLY_CYC = 10000000,
    parameter int SCK_HALF     = 5,
    parameter int DLY_W        = 24
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       pwr_on_req_i,
    input  logic       soc_sck_i,
    input  logic       soc_mosi_i,
    input  logic       soc_dc_i,
    output logic       oled_sck_o,
    output logic       oled_mosi_o,
    output logic       oled_dc_o,
    output logic       oled_res_n_o,
    output logic       oled_vdd_n_o,
    output logic       oled_vbat_n_o,
    output logic       ready_o,
    output logic       busy_o,
    output logic [3:0] state_o
);
    import oled_seq_pkg::*;

    state_t state_q, state_d;

    logic [DLY_W-1:0] dly_cnt;
    logic [2:0]       idx_q;
    logic             cmd_go_q;

    logic       tx_start, tx_busy, tx_done, tx_sck, tx_mosi;
    logic [7:0] tx_data;

    logic vdd_n_d, vbat_n_d, res_n_d, ready_d;
    logic vdd_n_q, vbat_n_q, res_n_q, ready_q;

    function automatic logic [DLY_W-1:0] entry_dly(input state_t s);
        case (s)
            ST_VDD_ON, ST_VDD_OFF:   entry_dly = DLY_W'(VDD_DLY_CYC - 1);
            ST_RST_LO, ST_RST_HI:    entry_dly = DLY_W'(RST_CYC - 1);
            ST_VBAT_ON, ST_VBAT_OFF: entry_dly = DLY_W'(VBAT_DLY_CYC - 1);
            default:                 entry_dly = '0;
        endcase
    endfunction

    function automatic logic is_cmd(input state_t s);
        return (s == ST_INIT_CMD) || (s == ST_DISP_ON) || (s == ST_DISP_OFF);
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_OFF;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OFF:      if (pwr_on_req_i)  state_d = ST_VDD_ON;
            ST_VDD_ON:   if (dly_cnt == '0) state_d = ST_RST_LO;
            ST_RST_LO:   if (dly_cnt == '0) state_d = ST_RST_HI;
            ST_RST_HI:   if (dly_cnt == '0) state_d = ST_INIT_CMD;
            ST_INIT_CMD: if (tx_done && idx_q == 3'(INIT_LEN)) state_d = ST_VBAT_ON;
            ST_VBAT_ON:  if (dly_cnt == '0) state_d = ST_DISP_ON;
            ST_DISP_ON:  if (tx_done)       state_d = ST_ON;
            ST_ON:       if (!pwr_on_req_i) state_d = ST_DISP_OFF;
            ST_DISP_OFF: if (tx_done)       state_d = ST_VBAT_OFF;
            ST_VBAT_OFF: if (dly_cnt == '0) state_d = ST_VDD_OFF;
            ST_VDD_OFF:  if (dly_cnt == '0) state_d = ST_OFF;
            default:                        state_d = ST_OFF;
        endcase
    end

    always_comb begin
        vdd_n_d  = !(state_q inside {[ST_VDD_ON:ST_VBAT_OFF]});
        vbat_n_d = !(state_q inside {[ST_VBAT_ON:ST_DISP_OFF]});
        res_n_d  = (state_q != ST_RST_LO);
        ready_d  = (state_q == ST_ON);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vdd_n_q  <= 1'b1;
            vbat_n_q <= 1'b1;
            res_n_q  <= 1'b1;
            ready_q  <= 1'b0;
        end else begin
            vdd_n_q  <= vdd_n_d;
            vbat_n_q <= vbat_n_d;
            res_n_q  <= res_n_d;
            ready_q  <= ready_d;
        end
    end

    // Delay counter and byte index are reloaded on every state change.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dly_cnt  <= '0;
            idx_q    <= '0;
            cmd_go_q <= 1'b0;
        end else begin
            cmd_go_q <= (state_d != state_q) && is_cmd(state_d);
            if (state_d != state_q)  dly_cnt <= entry_dly(state_d);
            else if (dly_cnt != '0)  dly_cnt <= dly_cnt - 1'b1;
            if (state_d != state_q)  idx_q <= '0;
            else if (tx_start)       idx_q <= idx_q + 1'b1;
        end
    end

    // First byte on entry; further init bytes chain off done with no gap.
    assign tx_start = !tx_busy &&
                      (cmd_go_q || (state_q == ST_INIT_CMD && tx_done && idx_q != 3'(INIT_LEN)));

    always_comb begin
        case (state_q)
            ST_INIT_CMD: tx_data = init_byte(idx_q);
            ST_DISP_ON:  tx_data = CMD_DISP_ON;
            default:     tx_data = CMD_DISP_OFF;
        endcase
    end

    oled_spi_tx #(.SCK_HALF(SCK_HALF)) u_spi_tx (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (tx_start),
        .data_i  (tx_data),
        .sck_o   (tx_sck),
        .mosi_o  (tx_mosi),
        .busy_o  (tx_busy),
        .done_o  (tx_done)
    );

    always_comb begin
        if (state_q == ST_ON) begin
            oled_sck_o  = soc_sck_i;
            oled_mosi_o = soc_mosi_i;
            oled_dc_o   = soc_dc_i;
        end else begin
            oled_sck_o  = tx_sck;
            oled_mosi_o = tx_mosi;
            oled_dc_o   = 1'b0;
        end
    end

    assign oled_vdd_n_o  = vdd_n_q;
    assign oled_vbat_n_o = vbat_n_q;
    assign oled_res_n_o  = res_n_q;
    assign ready_o       = ready_q;
    assign busy_o        = (state_q != ST_OFF) && (state_q != ST_ON);
    assign state_o       = state_q;

endmodule
